// File: rtl/pipelined_prefix_addsub.sv
// pipelined_prefix_addsub
//   Pipelined WIDTH-bit add / subtract-with-borrow built on a Brent-Kung
//   parallel-prefix carry network. LATENCY register stages are spread
//   evenly over the pre-computation, prefix and post-computation levels.
//   Valid/ready handshakes are provided on both sides. The whole pipe either
//   shifts together or holds together, so bubbles are never collapsed.
//
//   Optional build macro: PPA_SATURATE_EN
//     When defined, a result with signed overflow is clamped to the most
//     positive or most negative value, chosen by the sign of operand a.
//     zero is then taken from the clamped value. cout and ovf still describe
//     the raw result.
//
// Parameters
//   WIDTH    operand/result width (>= 2)
//   LATENCY  register stages from input acceptance to output valid (1..4)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    operand beat present
//   in_ready    a beat can be accepted this cycle (combinational)
//   a, b        operands
//   cin         carry-in (add) / not-borrow-in (sub)
//   sub         0: a+b+cin   1: a+~b+cin
//   out_valid   result beat present
//   out_ready   downstream accepts the result
//   sum         result bits
//   cout        carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   ovf         signed overflow of this result
//   zero        sum == 0
//   ovf_sticky  set on any accepted overflowing result
//   ovf_clr     synchronous clear of ovf_sticky (a simultaneous set wins)
module pipelined_prefix_addsub #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    // Position 0 of the prefix tree carries cin (G=cin, P=0). Positions
    // 1..WIDTH carry operand bits 0..WIDTH-1. The tree is padded to a power
    // of two; the padding positions hold zeros and never reach the result.
    localparam int NPOS  = WIDTH + 1;
    localparam int LG    = $clog2(NPOS);
    localparam int NP    = 1 << LG;
    localparam int NLEV  = 2 * LG - 1;       // up-sweep + down-sweep levels
    localparam int NSTEP = NLEV + 2;         // pre + prefix levels + post

    typedef struct packed {
        logic [NP-1:0]    g;
        logic [NP-1:0]    p;
        logic [WIDTH-1:0] pt;    // per-bit half sum, kept for the final xor
        logic             amsb;  // sign of operand a, used by the clamp
    } bus_t;

    // A mid-pipeline register r sits after boundary(r) completed steps.
    function automatic int boundary(input int r);
        return ((r + 1) * NSTEP) / LATENCY;
    endfunction

    // Index of the mid register feeding step s, or -1 if s is fed by wires.
    function automatic int mid_at(input int s);
        int idx;
        idx = -1;
        for (int r = 0; r < LATENCY - 1; r++) begin
            if (boundary(r) == s) idx = r;
        end
        return idx;
    endfunction

    // One Brent-Kung level. Levels 1..LG are the up-sweep (span doubles),
    // levels LG+1..2*LG-1 are the down-sweep (span halves) that fills in the
    // positions the up-sweep skipped.
    function automatic bus_t prefix_level(input bus_t x, input int lv);
        bus_t y;
        int   span;
        int   d;
        int   lo;
        logic up;
        y    = x;
        up   = (lv <= LG);
        span = up ? (1 << lv) : (1 << (2 * LG - lv));
        d    = span / 2;
        for (int j = 0; j < NP; j++) begin
            lo = (j >= d) ? j - d : 0;
            if (up ? (((j + 1) % span) == 0)
                   : ((((j + 1) % span) == d) && (j >= span))) begin
                y.g[j] = x.g[j] | (x.p[j] & x.g[lo]);
                y.p[j] = x.p[j] & x.p[lo];
            end
        end
        return y;
    endfunction

    genvar gi;

    logic [LATENCY-1:0] valid_reg;
    logic               advance;
    logic               final_load;

    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               zero_reg;
    logic               ovf_sticky_reg;

    bus_t               pre_bus;
    bus_t               step_out [0:NSTEP-2];
    bus_t               step_in  [1:NSTEP-1];

    logic [WIDTH-1:0]   sum_next;
    logic               cout_next;
    logic               ovf_next;
    logic               zero_next;

    assign advance   = !valid_reg[LATENCY-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_reg[LATENCY-1];

    // Pre-computation: generate/propagate per bit with optional inversion of b.
    always_comb begin
        logic [WIDTH-1:0] bp;
        bp           = sub ? ~b : b;
        pre_bus      = '0;
        pre_bus.g[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            pre_bus.g[i+1] = a[i] & bp[i];
            pre_bus.p[i+1] = a[i] ^ bp[i];
        end
        pre_bus.pt   = a ^ bp;
        pre_bus.amsb = a[WIDTH-1];
    end

    assign step_out[0] = pre_bus;

    // Mid-pipeline data registers; each loads only when a valid beat enters.
    for (gi = 0; gi < LATENCY - 1; gi++) begin : g_mid
        localparam int SRC = boundary(gi) - 1;
        logic stage_load;
        bus_t data_reg;

        if (gi == 0) begin : g_first
            assign stage_load = in_valid;
        end else begin : g_later
            assign stage_load = valid_reg[gi-1];
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                data_reg <= '0;
            end else if (advance && stage_load) begin
                data_reg <= step_out[SRC];
            end
        end
    end

    // Each step reads either the previous step directly or a pipeline register.
    for (gi = 1; gi < NSTEP; gi++) begin : g_in
        localparam int MIDX = mid_at(gi);
        if (MIDX >= 0) begin : g_reg
            assign step_in[gi] = g_mid[MIDX].data_reg;
        end else begin : g_wire
            assign step_in[gi] = step_out[gi-1];
        end
    end

    for (gi = 1; gi < NSTEP - 1; gi++) begin : g_lvl
        assign step_out[gi] = prefix_level(step_in[gi], gi);
    end

    // Post-computation: after the tree, g[i] is the carry into operand bit i.
    always_comb begin
        sum_next  = step_in[NSTEP-1].pt ^ step_in[NSTEP-1].g[WIDTH-1:0];
        cout_next = step_in[NSTEP-1].g[WIDTH];
        ovf_next  = step_in[NSTEP-1].g[WIDTH-1] ^ step_in[NSTEP-1].g[WIDTH];
`ifdef PPA_SATURATE_EN
        if (ovf_next) begin
            sum_next = step_in[NSTEP-1].amsb ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_next = ~|sum_next;
    end

    if (LATENCY == 1) begin : g_final_in
        assign final_load = in_valid;
    end else begin : g_final_mid
        assign final_load = valid_reg[LATENCY-2];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg      <= '0;
            sum_reg        <= '0;
            cout_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            zero_reg       <= 1'b0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            if (advance) begin
                for (int k = LATENCY - 1; k > 0; k--) begin
                    valid_reg[k] <= valid_reg[k-1];
                end
                valid_reg[0] <= in_valid;
                if (final_load) begin
                    sum_reg  <= sum_next;
                    cout_reg <= cout_next;
                    ovf_reg  <= ovf_next;
                    zero_reg <= zero_next;
                end
            end
            // A qualifying handshake takes priority over a clear.
            if (valid_reg[LATENCY-1] && out_ready && ovf_reg) begin
                ovf_sticky_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky_reg <= 1'b0;
            end
        end
    end

    assign sum        = sum_reg;
    assign cout       = cout_reg;
    assign ovf        = ovf_reg;
    assign zero       = zero_reg;
    assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Testbench for pipelined_prefix_addsub (WIDTH=32, LATENCY=2).
// Table-driven arithmetic vectors streamed back to back, followed by
// hand-written sequences for sticky overflow, back-pressure and reset.
module tb_pipelined_prefix_addsub;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;
    localparam int NV      = 13;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             ovf_sticky;
    logic             ovf_clr;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [NV];

    pipelined_prefix_addsub #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int got;
        int sent;
        int rcv;
        logic [31:0] held;
        logic acc;
        logic hs;

        checks = 0;
        errors = 0;

        //           a             b             cin   sub   sum           cout  ovf   zero
        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h00001234, 32'h00001234, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};

`ifdef PPA_SATURATE_EN
        // Overflowing results clamp toward the sign of operand a.
        vecs[0].sum  = 32'h7FFFFFFF;
        vecs[4].sum  = 32'h80000000;
        vecs[5].sum  = 32'h80000000;
        vecs[5].zero = 1'b0;
        vecs[10].sum = 32'h7FFFFFFF;
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);

        // Table vectors, streamed one per cycle
        got = 0;
        for (int cyc = 0; cyc < NV + 20 && got < NV; cyc++) begin
            if (cyc < NV) begin
                a        = vecs[cyc].a;
                b        = vecs[cyc].b;
                cin      = vecs[cyc].cin;
                sub      = vecs[cyc].sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (cyc < NV) chk("stream_in_ready", 64'(in_ready), 64'd1);
            @(posedge clock);
            #1;
            if (out_valid) begin
                if (got == 0) chk("latency", 64'(cyc), 64'd1);
                chk($sformatf("v%0d_sum", got), 64'(sum), 64'(vecs[got].sum));
                chk($sformatf("v%0d_cout", got), 64'(cout), 64'(vecs[got].cout));
                chk($sformatf("v%0d_ovf", got), 64'(ovf), 64'(vecs[got].ovf));
                chk($sformatf("v%0d_zero", got), 64'(zero), 64'(vecs[got].zero));
                $display("vec %0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d",
                         got, vecs[got].a, vecs[got].b, vecs[got].cin, vecs[got].sub,
                         sum, cout, ovf, zero);
                got++;
            end
        end
        in_valid = 1'b0;
        chk("vec_count", 64'(got), 64'(NV));
        chk("sticky_after_stream", 64'(ovf_sticky), 64'd1);

        // Clear alone (last result does not overflow)
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
        chk("drained", 64'(out_valid), 64'd0);

        // Clear on the same edge as an overflowing handshake: set wins
        a        = 32'h7FFFFFFF;
        b        = 32'h00000001;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sim_out_valid", 64'(out_valid), 64'd1);
        chk("sim_ovf", 64'(ovf), 64'd1);
        chk("sim_sticky_before", 64'(ovf_sticky), 64'd0);
        ovf_clr = 1'b1;
        tick();
        chk("sim_sticky_set_wins", 64'(ovf_sticky), 64'd1);
        chk("sim_empty", 64'(out_valid), 64'd0);
        tick();
        ovf_clr = 1'b0;
        chk("sim_sticky_clr_next", 64'(ovf_sticky), 64'd0);
        $display("sticky sequence done sticky=%0d", ovf_sticky);

        // Back-pressure: 8 beats a=i b=i, out_ready low in cycles 3..6
        sent = 0;
        rcv  = 0;
        held = '0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 8);
            a         = 32'(sent);
            b         = 32'(sent);
            cin       = 1'b0;
            sub       = 1'b0;
            #1;
            if (c >= 3 && c <= 6) begin
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (c == 3) held = sum;
                else chk("stall_hold_sum", 64'(sum), 64'(held));
            end
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                chk($sformatf("stream_r%0d", rcv), 64'(sum), 64'(2 * rcv));
                $display("stream beat %0d sum=%0d", rcv, sum);
                rcv++;
            end
            @(posedge clock);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(rcv), 64'd8);
        tick();
        tick();
        chk("stream_no_extra", 64'(out_valid), 64'd0);

        // Reset with beats in flight
        a        = 32'h7FFFFFFF;
        b        = 32'h00000001;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_sticky", 64'(ovf_sticky), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_sum", 64'(sum), 64'd0);
        chk("async_rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            tick();
        end
        $display("reset sequence done out_valid=%0d", out_valid);

        // Normal operation resumes after reset
        a        = 32'h12345678;
        b        = 32'h11111111;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("resume_valid", 64'(out_valid), 64'd1);
        chk("resume_sum", 64'(sum), 64'h2345678A);
        $display("resume beat sum=%h", sum);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_addsub.md
Name: pipelined_prefix_addsub

Overview:
- Parametrised, pipelined successor to the team's 32-bit combinational prefix adder.
- Computes WIDTH-bit signed/unsigned add or subtract-with-borrow through a Brent-Kung style prefix network.
- Pipeline registers are inserted across the prefix levels, with valid/ready handshakes on both sides.
- Used as the ALU add path when the datapath is retimed for higher clock rates, and for multi-word chained arithmetic via cin/cout.

Parameters:
- WIDTH, 32, operand/result width; any integer >= 2.
- LATENCY, 2, register stages from input acceptance to output valid; legal 1..4; stages are spread evenly over the pre-computation, prefix and post-computation levels.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / not-borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a+~b+cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow of this result.
- zero  output  1  sum == 0.
- ovf_sticky  output  1  latched overflow flag.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Arithmetic:
  - G0 = cin and P0 = 0 feed the prefix tree.
  - Per bit: Gi = a[i] & b'[i], Pi = a[i] ^ b'[i], where b' = sub ? ~b : b.
  - sum[i] = Pi ^ carry-into-i.
  - cout = carry out of MSB.
  - ovf = carry-into-MSB ^ cout.
  - Subtraction a-b requires cin=1. For sub=1, cout=1 means no borrow.
- Pipeline:
  - One valid bit per stage.
  - advance = !out_valid | out_ready; in_ready = advance, combinational.
  - On advance, every stage shifts one position. Stage 0 loads in_valid & data.
  - Bubbles are not collapsed: the whole pipe shifts together or holds together.
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+LATENCY-1 (first register at edge N), provided out_ready stayed high.
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 & out_ready=0, all stages hold, in_ready=0, and sum/cout/ovf/zero are stable.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Sticky overflow:
  - ovf_sticky sets on an output handshake (out_valid & out_ready) with ovf=1.
  - ovf_clr=1 clears it on the next edge.
  - Simultaneous clear and a qualifying handshake: set wins, sticky=1.
- Reset (asserted any time, including mid-operation):
  - All stage valids = 0, out_valid = 0, and all data registers = 0.
  - Outputs sum/cout/ovf/zero = 0, ovf_sticky = 0.
  - in_ready = 1 after reset, because out_valid=0.
  - In-flight beats are discarded.
- Output data while out_valid=0 is don't-care to consumers but must be deterministic (held or reset values).
- WIDTH not a power of two: the prefix tree is padded conceptually. Results must match the arithmetic definition above for all inputs.

Optional Feature:
- Macro: PPA_SATURATE_EN.
- Defined:
  - When ovf=1, sum is clamped to signed saturation: the most-positive value (0 followed by all ones) if a' is non-negative, else the most-negative value (1 followed by all zeros), where a' is operand a's MSB.
  - zero is evaluated on the clamped value. ovf and cout still report the raw (unsaturated) result.
  - Clamp is applied in the final stage; latency is unchanged.
- Not defined: sum is the raw wrapped result; no clamp logic is present.

Test Plan:
- WIDTH=32, LATENCY=2, a=0x7FFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> after 2 edges: sum=0x80000000, ovf=1, cout=0, zero=0; ovf_sticky=1 after the handshake edge.
- sub=1, cin=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=b=0x1234, sub=1, cin=1 -> sum=0, zero=1, cout=1.
- Stream 8 beats a=i, b=i; drop out_ready for cycles 3-6 -> in_ready=0 during the stall, outputs stable, then results 0,2,4,...,14 in order with no loss or duplication.
- Assert reset with 2 beats in flight -> out_valid=0 immediately (asynchronously), ovf_sticky=0, in_ready=1 once out_valid=0; no stale beat emerges after release.
- ovf_clr=1 on the same edge as an accepted overflowing result -> ovf_sticky stays 1. ovf_clr alone on the next edge -> 0.
- PPA_SATURATE_EN defined: 0x7FFFFFFF+1 -> sum=0x7FFFFFFF, ovf=1. 0x80000000-1 (sub=1, cin=1) -> sum=0x80000000, ovf=1, cout=1.
